// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one cache/memory port between instruction fetch and
//               MEM-stage data accesses. Data has priority; a fetch that was
//               waiting behind a data access is served straight after it.
//               A watchdog aborts accesses that never see port_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  // data requester
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic              mem_is_word,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  // pipeline control
  output logic              pipe_stall,
  // memory port
  output logic              port_req,
  output logic              port_we,
  output logic              port_is_word,
  output logic [DATA_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  input  logic [DATA_W-1:0] port_rdata,
  input  logic              port_ready,
  output logic              err
);

  localparam int              CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_INST = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;

  logic              r_port_req;
  logic              r_port_we;
  logic              r_port_is_word;
  logic [DATA_W-1:0] r_port_addr;
  logic [DATA_W-1:0] r_port_wdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_mem_done;
  logic              r_if_done;
  logic              r_err;
  logic              r_fetch_owed;
  logic [CNT_W-1:0]  r_wait_cnt;

  // Requests still waiting for service; a request whose done pulse is high
  // this cycle is the one just finished and must not be granted again.
  logic w_data_pending;
  logic w_fetch_pending;
  logic w_can_grant;

  logic w_grant_data;
  logic w_grant_inst;
  logic w_complete;
  logic w_timeout;

  assign w_data_pending  = mem_req & ~r_mem_done;
  assign w_fetch_pending = if_req & ~r_if_done;
  assign w_can_grant     = ~halted & ~r_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: INST with port_req low is the hand-off cycle after a data
  // access that owed the fetch a slot.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_data) begin
          w_state_next = S_DATA;
        end else if (w_grant_inst) begin
          w_state_next = S_INST;
        end
      end
      S_DATA: begin
        if (!r_port_req || w_timeout) begin
          w_state_next = S_IDLE;
        end else if (w_complete) begin
          w_state_next = (r_fetch_owed && w_fetch_pending && w_can_grant) ? S_INST : S_IDLE;
        end
      end
      S_INST: begin
        if (!r_port_req) begin
          w_state_next = w_grant_inst ? S_INST : S_IDLE;
        end else if (w_complete || w_timeout) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state and inputs
  always_comb begin
    w_grant_data = 1'b0;
    w_grant_inst = 1'b0;
    w_complete   = r_port_req & port_ready;
    w_timeout    = r_port_req & ~port_ready & (r_wait_cnt == WAIT_LAST);
    case (r_state)
      S_IDLE: begin
        if (w_can_grant) begin
          if (w_data_pending) begin
            w_grant_data = 1'b1;
          end else if (w_fetch_pending) begin
            w_grant_inst = 1'b1;
          end
        end
      end
      S_INST: begin
        if (!r_port_req && w_can_grant && w_fetch_pending) begin
          w_grant_inst = 1'b1;
        end
      end
      default: begin
        w_grant_data = 1'b0;
        w_grant_inst = 1'b0;
      end
    endcase
  end

  // Port latches, completion capture, watchdog and fetch-owed bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port_req     <= 1'b0;
      r_port_we      <= 1'b0;
      r_port_is_word <= 1'b0;
      r_port_addr    <= '0;
      r_port_wdata   <= '0;
      r_mem_rdata    <= '0;
      r_if_rdata     <= '0;
      r_mem_done     <= 1'b0;
      r_if_done      <= 1'b0;
      r_err          <= 1'b0;
      r_fetch_owed   <= 1'b0;
      r_wait_cnt     <= '0;
    end else begin
      r_mem_done <= 1'b0;
      r_if_done  <= 1'b0;

      if (w_grant_data) begin
        r_port_req     <= 1'b1;
        r_port_we      <= mem_we;
        r_port_is_word <= mem_is_word;
        r_port_addr    <= mem_addr;
        r_port_wdata   <= mem_wdata;
        r_wait_cnt     <= '0;
        r_fetch_owed   <= w_fetch_pending;
      end else if (w_grant_inst) begin
        r_port_req     <= 1'b1;
        r_port_we      <= 1'b0;
        r_port_is_word <= 1'b1;
        r_port_addr    <= if_addr;
        r_port_wdata   <= '0;
        r_wait_cnt     <= '0;
        r_fetch_owed   <= 1'b0;
      end else if (r_port_req) begin
        if (port_ready) begin
          r_port_req <= 1'b0;
          if (r_state == S_DATA) begin
            r_mem_done  <= 1'b1;
            r_mem_rdata <= port_rdata;
          end else begin
            r_if_done  <= 1'b1;
            r_if_rdata <= port_rdata;
          end
        end else if (w_timeout) begin
          r_port_req <= 1'b0;
          r_err      <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign port_req     = r_port_req;
  assign port_we      = r_port_we;
  assign port_is_word = r_port_is_word;
  assign port_addr    = r_port_addr;
  assign port_wdata   = r_port_wdata;
  assign mem_rdata    = r_mem_rdata;
  assign if_rdata     = r_if_rdata;
  assign mem_done     = r_mem_done;
  assign if_done      = r_if_done;
  assign err          = r_err;

  // Stall the pipeline while either requester is still waiting
  assign pipe_stall = (mem_req & ~r_mem_done) | (if_req & ~r_if_done);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter: directed scenarios
//               plus randomized requesters/port against a transaction-level
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset, halted;
  logic          if_req, mem_req, mem_we, mem_is_word, port_ready;
  logic [DW-1:0] if_addr, mem_addr, mem_wdata, port_rdata;
  logic [DW-1:0] if_rdata, mem_rdata, port_addr, port_wdata;
  logic          if_done, mem_done, pipe_stall, port_req, port_we, port_is_word, err;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: who owns the port (0 none, 1 data, 2 fetch) and its latches
  int            m_owner;
  bit            m_preq, m_we, m_word, m_mdone, m_idone, m_err, m_owed;
  logic [DW-1:0] m_addr, m_wdata, m_mrdata, m_irdata;
  int            m_wait;

  mem_port_arbiter #(.DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_is_word(mem_is_word),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .pipe_stall(pipe_stall),
    .port_req(port_req), .port_we(port_we), .port_is_word(port_is_word),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_rdata(port_rdata),
    .port_ready(port_ready), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic grant_fetch();
    m_owner = 2; m_preq = 1; m_we = 0; m_word = 1;
    m_addr = if_addr; m_wdata = '0; m_wait = 0; m_owed = 0;
  endtask

  // One clock of the reference model, applied with the inputs seen at the edge
  task automatic model_step();
    bit old_md, old_id, free;
    old_md = m_mdone; old_id = m_idone;
    m_mdone = 0; m_idone = 0;
    if (reset) begin
      m_owner = 0; m_preq = 0; m_we = 0; m_word = 0; m_err = 0; m_owed = 0;
      m_addr = '0; m_wdata = '0; m_mrdata = '0; m_irdata = '0; m_wait = 0;
    end else if (m_preq) begin
      if (port_ready) begin
        m_preq = 0;
        if (m_owner == 1) begin
          m_mdone = 1; m_mrdata = port_rdata;
          m_owner = (m_owed && if_req && !halted) ? 2 : 0;
        end else begin
          m_idone = 1; m_irdata = port_rdata; m_owner = 0;
        end
      end else if (m_wait == MW - 1) begin
        m_err = 1; m_preq = 0; m_owner = 0;
      end else begin
        m_wait++;
      end
    end else begin
      free = !halted && !m_err;
      if (m_owner == 2) begin
        if (free && if_req) grant_fetch();
        else m_owner = 0;
      end else if (free) begin
        if (mem_req && !old_md) begin
          m_owner = 1; m_preq = 1; m_we = mem_we; m_word = mem_is_word;
          m_addr = mem_addr; m_wdata = mem_wdata; m_wait = 0;
          m_owed = if_req && !old_id;
        end else if (if_req && !old_id) begin
          grant_fetch();
        end
      end
    end
  endtask

  task automatic compare_all();
    check("port_req", port_req, m_preq);
    check("port_we", port_we, m_we);
    check("port_is_word", port_is_word, m_word);
    check("port_addr", port_addr, m_addr);
    check("port_wdata", port_wdata, m_wdata);
    check("mem_done", mem_done, m_mdone);
    check("if_done", if_done, m_idone);
    check("mem_rdata", mem_rdata, m_mrdata);
    check("if_rdata", if_rdata, m_irdata);
    check("err", err, m_err);
    check("pipe_stall", pipe_stall, (mem_req & ~m_mdone) | (if_req & ~m_idone));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic new_data_req();
    mem_req = 1; mem_we = 1'($urandom); mem_is_word = 1'($urandom);
    mem_addr = $urandom; mem_wdata = $urandom;
  endtask

  initial begin
    int back_to_back, fetch_grants, last_kind;
    bit prev_preq;
    reset = 1; halted = 0; if_req = 0; mem_req = 0; mem_we = 0; mem_is_word = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; port_rdata = '0; port_ready = 0;
    m_owner = 0; m_preq = 0; m_we = 0; m_word = 0; m_mdone = 0; m_idone = 0; m_err = 0;
    m_owed = 0; m_addr = '0; m_wdata = '0; m_mrdata = '0; m_irdata = '0; m_wait = 0;

    // reset state
    tick(); tick();
    check("rst_port_req", port_req, 0);
    check("rst_err", err, 0);
    check("rst_dones", {mem_done, if_done}, 0);
    reset = 0;
    tick();

    // lone load, port_ready three cycles after port_req
    mem_req = 1; mem_we = 0; mem_is_word = 1; mem_addr = 32'h100;
    tick();
    check("load_port_req", port_req, 1);
    check("load_port_addr", port_addr, 32'h100);
    tick(); tick();
    check("load_stall", pipe_stall, 1);
    port_ready = 1; port_rdata = 32'hDEADBEEF;
    tick();
    check("load_done", mem_done, 1);
    check("load_rdata", mem_rdata, 32'hDEADBEEF);
    check("load_req_drop", port_req, 0);
    check("load_stall_clear", pipe_stall, 0);
    mem_req = 0; port_ready = 0;
    tick();
    check("load_done_pulse", mem_done, 0);

    // simultaneous fetch and store: data first, fetch handed over directly
    if_req = 1; if_addr = 32'h200;
    mem_req = 1; mem_we = 1; mem_is_word = 1; mem_addr = 32'h40; mem_wdata = 32'h55;
    tick();
    check("sim_we", port_we, 1);
    check("sim_addr", port_addr, 32'h40);
    check("sim_wdata", port_wdata, 32'h55);
    port_ready = 1;
    tick();
    check("sim_mem_done", mem_done, 1);
    mem_req = 0; port_ready = 0;
    tick();
    check("sim_inst_grant", port_req, 1);
    check("sim_inst_addr", port_addr, 32'h200);
    check("sim_inst_we", port_we, 0);
    port_ready = 1; port_rdata = 32'h1234_5678;
    tick();
    check("sim_if_done", if_done, 1);
    check("sim_if_rdata", if_rdata, 32'h1234_5678);
    if_req = 0; port_ready = 0;
    tick();

    // starvation: data re-requested continuously, fetch held
    back_to_back = 0; fetch_grants = 0; last_kind = 0; prev_preq = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h1000; if_req = 1; if_addr = 32'h2000;
    port_ready = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (port_req && !prev_preq) begin
        if (port_addr[13:12] == 2'b10) begin
          fetch_grants++; last_kind = 2;
        end else begin
          if (last_kind == 1) back_to_back++;
          last_kind = 1;
        end
      end
      prev_preq = port_req;
      if (mem_done) mem_addr = mem_addr + 4;
      if (if_done) if_addr = if_addr + 4;
    end
    check("starve_back_to_back", back_to_back, 0);
    check("starve_fetch_served", fetch_grants >= 8, 1);
    mem_req = 0; if_req = 0; port_ready = 0;
    tick(); tick(); tick();

    // watchdog timeout
    mem_req = 1; mem_we = 0; mem_addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("to_req_held", port_req, 1);
    end
    tick();
    check("to_err", err, 1);
    check("to_req_drop", port_req, 0);
    check("to_no_done", mem_done, 0);
    check("to_stall", pipe_stall, 1);
    if_req = 1;
    tick(); tick();
    check("to_no_grant", port_req, 0);
    check("to_err_sticky", err, 1);
    mem_req = 0; if_req = 0; reset = 1;
    tick();
    reset = 0;
    tick();

    // reset in the middle of a fetch
    if_req = 1; if_addr = 32'h300;
    tick();
    check("rm_req", port_req, 1);
    reset = 1; port_ready = 1;
    tick();
    check("rm_req_clear", port_req, 0);
    check("rm_no_done", if_done, 0);
    check("rm_err", err, 0);
    reset = 0; if_req = 0; port_ready = 0;
    tick();

    // halted during a data access
    mem_req = 1; mem_we = 1; mem_addr = 32'h44; mem_wdata = 32'hA5; if_req = 1; if_addr = 32'h400;
    tick();
    halted = 1; port_ready = 1;
    tick();
    check("halt_mem_done", mem_done, 1);
    mem_req = 0; port_ready = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_no_grant", port_req, 0);
    end
    halted = 0;
    tick();
    check("unhalt_grant", port_req, 1);
    port_ready = 1;
    tick();
    if_req = 0; port_ready = 0;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if (mem_req) begin
        if (m_mdone) begin
          if ($urandom_range(0, 1) == 1) new_data_req();
          else mem_req = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        new_data_req();
      end
      if (if_req) begin
        if (m_idone) begin
          if ($urandom_range(0, 1) == 1) if_addr = $urandom;
          else if_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      halted     = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 499) == 0) || (m_err && $urandom_range(0, 3) == 0);
      port_ready = ($urandom_range(0, 9) < 6);
      port_rdata = $urandom;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
